prime_collector: RTL
====================

PRIME_COLLECTOR -- requirements
Module: prime_collector

Interface
REQ-001 Parameter WIDTH, default 16: width of generator result and FIFO data.
REQ-002 Parameter DEPTH, default 8: FIFO entries; power of two, >= 2.
REQ-003 clk  input  1: single clock; all state updates on posedge clk.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 en  input  1: run enable; while high the block keeps requesting primes.
REQ-006 gen_go  output  1: one-cycle request pulse to the prime generator.
REQ-007 gen_ready  input  1: generator idle / result valid (level).
REQ-008 gen_error  input  1: generator overflow flag; valid while gen_ready high.
REQ-009 gen_res  input  WIDTH: generator result; valid while gen_ready high.
REQ-010 pop  input  1: consumer read strobe; ignored when empty.
REQ-011 dout  output  WIDTH: FIFO head entry; valid when !empty.
REQ-012 empty  output  1: FIFO holds no entries.
REQ-013 full  output  1: FIFO holds DEPTH entries.
REQ-014 done  output  1: sticky; generator reported overflow, no further requests.
REQ-015 prime_count  output  32: number of primes pushed since reset; wraps at 2^32.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT_LO, WAIT_HI, STOP; reset state IDLE.
REQ-017 IDLE -> ISSUE when en=1, done=0, gen_ready=1, and occupancy < DEPTH.
REQ-018 ISSUE: gen_go=1 for exactly one cycle; next state WAIT_LO.
REQ-019 WAIT_LO: stay until gen_ready=0, then WAIT_HI.
REQ-020 WAIT_HI: on first cycle with gen_ready=1: if gen_error=1, go to STOP, set done; else push gen_res into FIFO, increment prime_count, go to IDLE.
REQ-021 STOP: absorbing until rst; gen_go held 0; FIFO still drains via pop.
REQ-022 gen_go is 0 in every state except ISSUE.
REQ-023 At most one request in flight; no new request before the previous result is captured.
REQ-024 Full is checked before ISSUE, so a push in WAIT_HI never overflows; a push is never dropped.
REQ-025 en deasserted in WAIT_LO/WAIT_HI: outstanding request completes and its result is pushed; then block stays in IDLE.
REQ-026 FIFO first-word-fall-through: dout reflects the head combinationally from storage; pop with !empty advances head next cycle.
REQ-027 Simultaneous push and pop: occupancy unchanged, both take effect, including when full (push permitted because full blocked ISSUE only).
REQ-028 Simultaneous push and pop on an empty FIFO: push wins, pop ignored; empty deasserts next cycle.
REQ-029 Read/write pointers log2(DEPTH) bits, wrap modulo DEPTH; occupancy counter log2(DEPTH)+1 bits.
REQ-030 Result captured in WAIT_HI is gen_res sampled in that same cycle.

Reset
REQ-031 rst=1 at posedge: state IDLE, gen_go=0, empty=1, full=0, done=0, prime_count=0, pointers and occupancy 0; dout don't-care.
REQ-032 Reset mid-request aborts it; the generator is reset by the same rst.
REQ-033 No output other than dout is X after the first reset cycle.

Verification
REQ-034 Reset, en=1, generator model returns 2,3,5,7 with 3-cycle latency, no pop -> FIFO holds 2,3,5,7 in order; prime_count=4; gen_go pulses exactly 4 times, each 1 cycle wide.
REQ-035 en=1, no pop, DEPTH=8 -> after 8 pushes full=1, gen_go stays 0; one pop -> exactly one new request issued, full returns to 1.
REQ-036 Model asserts gen_error on the 5th result -> done=1, prime_count=4, no further gen_go; popping 4 times yields 2,3,5,7 then empty=1.
REQ-037 Push and pop in the same cycle with occupancy 3 -> occupancy stays 3, order preserved; with occupancy 0 -> occupancy becomes 1.
REQ-038 en dropped the cycle after gen_go -> that result is still pushed, no further gen_go while en=0.
REQ-039 rst asserted in WAIT_HI with 2 entries stored -> next cycle empty=1, prime_count=0, done=0, state IDLE.

Source files
------------

// File: rtl/prime_collector_if.sv
// Handshake between the collector (master) and the external prime generator (slave).
interface prime_collector_if #(
  parameter int WIDTH = 16
) ();
  logic             gen_go;
  logic             gen_ready;
  logic             gen_error;
  logic [WIDTH-1:0] gen_res;

  modport master (output gen_go, input gen_ready, input gen_error, input gen_res);
  modport slave  (input gen_go, output gen_ready, output gen_error, output gen_res);
endinterface

// File: rtl/prime_collector.sv
// Requests primes from a generator one at a time and queues them in a
// first-word-fall-through FIFO until the generator reports overflow.
module prime_collector #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 pop,
  prime_collector_if.master    gen,
  output logic [WIDTH-1:0]     dout,
  output logic                 empty,
  output logic                 full,
  output logic                 done,
  output logic [31:0]          prime_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, STOP} state_t;

  state_t           state_reg, state_next;
  logic             push;
  logic             pop_ok;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic [31:0]      prime_count_reg;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Occupancy is checked before issuing, so a result arriving later always has room.
  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    case (state_reg)
      IDLE:    if (en && gen.gen_ready && (count_reg != FULL_CNT)) state_next = ISSUE;
      ISSUE:   state_next = WAIT_LO;
      WAIT_LO: if (!gen.gen_ready) state_next = WAIT_HI;
      WAIT_HI: begin
        if (gen.gen_ready) begin
          if (gen.gen_error) begin
            state_next = STOP;
          end else begin
            push       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      STOP:    state_next = STOP;
      default: state_next = IDLE;
    endcase
  end

  assign gen.gen_go = (state_reg == ISSUE);
  assign done       = (state_reg == STOP);

  // A pop against an empty FIFO is ignored even when a push lands in the same cycle.
  assign pop_ok = pop && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= gen.gen_res;
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      prime_count_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg      <= wr_ptr_reg + 1'b1;
        prime_count_reg <= prime_count_reg + 32'd1;
      end
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign dout        = mem[rd_ptr_reg];
  assign empty       = (count_reg == '0);
  assign full        = (count_reg == FULL_CNT);
  assign prime_count = prime_count_reg;
endmodule
